// File: rtl/rrp_pkg.sv
// Shared definitions for the redundant-radix (MSDF online) arithmetic blocks:
// derived widths, legal digit range and the on-the-fly converter state encoding.
package rrp_pkg;

  typedef enum logic {
    StAccum = 1'b0,
    StDone  = 1'b1
  } otfc_state_e;

  // Bits per conventional digit.
  function automatic int unsigned calc_k(input int unsigned radix);
    return $clog2(radix);
  endfunction

  // Signed-digit field width (one sign bit on top of K).
  function automatic int unsigned calc_d(input int unsigned radix);
    return calc_k(radix) + 1;
  endfunction

  function automatic int unsigned calc_out_w(input int unsigned radix, input int unsigned width);
    return width * calc_k(radix) + 1;
  endfunction

  function automatic int digit_max(input int unsigned radix);
    return int'(radix) - 1;
  endfunction

  function automatic int digit_min(input int unsigned radix);
    return -(int'(radix) - 1);
  endfunction

endpackage

// File: rtl/rrp_otfc_step.sv
// Combinational on-the-fly conversion step: Q/QM next values from Q, QM and one signed digit,
// built purely from K-bit shifts and concatenation.
module rrp_otfc_step
  import rrp_pkg::*;
#(
  parameter int unsigned RADIX = 4,
  parameter int unsigned WIDTH = 15,
  localparam int unsigned K     = calc_k(RADIX),
  localparam int unsigned D     = calc_d(RADIX),
  localparam int unsigned OUT_W = calc_out_w(RADIX, WIDTH)
) (
  input  logic [OUT_W-1:0] q_i,
  input  logic [OUT_W-1:0] qm_i,
  input  logic [D-1:0]     digit_i,
  output logic [OUT_W-1:0] q_next_o,
  output logic [OUT_W-1:0] qm_next_o
);

  logic [D-1:0] digit_m1;
  logic [K-1:0] q_fld;
  logic [K-1:0] qm_fld;
  logic         digit_neg;
  logic         digit_pos;
  logic         unused_hi;

  // The top K bits are shifted out by every update.
  assign unused_hi = ^{q_i[OUT_W-1:OUT_W-K], qm_i[OUT_W-1:OUT_W-K]};

  always_comb begin
    digit_neg = digit_i[D-1];
    digit_pos = !digit_i[D-1] && (digit_i != '0);
    digit_m1  = digit_i - D'(1);
    // RADIX+d and RADIX-1+d share their low K bits with d and d-1, as RADIX = 2^K.
    q_fld     = digit_i[K-1:0];
    qm_fld    = digit_m1[K-1:0];
    q_next_o  = digit_neg ? {qm_i[OUT_W-K-1:0], q_fld} : {q_i[OUT_W-K-1:0], q_fld};
    qm_next_o = digit_pos ? {q_i[OUT_W-K-1:0], qm_fld} : {qm_i[OUT_W-K-1:0], qm_fld};
  end

endmodule

// File: rtl/rrp_otfc.sv
// Serial MSD-first signed-digit to two's-complement converter with valid/ready handshakes.
// Optional illegal-digit detection is enabled by defining RRP_OTFC_DIGIT_CHECK_EN.
module rrp_otfc
  import rrp_pkg::*;
#(
  parameter int unsigned RADIX = 4,
  parameter int unsigned WIDTH = 15,
  localparam int unsigned K     = calc_k(RADIX),
  localparam int unsigned D     = calc_d(RADIX),
  localparam int unsigned OUT_W = calc_out_w(RADIX, WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [D-1:0]            digit_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] result,
  output logic                    digit_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  otfc_state_e             state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [OUT_W-1:0] q_q, q_d;
  logic signed [OUT_W-1:0] qm_q, qm_d;
  logic signed [OUT_W-1:0] result_q, result_d;
  logic [OUT_W-1:0]        q_next;
  logic [OUT_W-1:0]        qm_next;
  logic                    accept;

  rrp_otfc_step #(
    .RADIX(RADIX),
    .WIDTH(WIDTH)
  ) u_step (
    .q_i      (q_q),
    .qm_i     (qm_q),
    .digit_i  (digit_in),
    .q_next_o (q_next),
    .qm_next_o(qm_next)
  );

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qm_d     = qm_q;
    result_d = result_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          if (cnt_q == CntW'(WIDTH - 1)) begin
            // Last digit: publish and rearm Q/QM for the next operand in the same cycle.
            result_d = q_next;
            q_d      = '0;
            qm_d     = '1;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            q_d   = q_next;
            qm_d  = qm_next;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StAccum;
      cnt_q    <= '0;
      q_q      <= '0;
      qm_q     <= '1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      result_q <= result_d;
    end
  end

`ifdef RRP_OTFC_DIGIT_CHECK_EN
  localparam int DigitMin = digit_min(RADIX);

  logic err_q, err_d;

  assign err_d     = err_q | (accept && (int'($signed(digit_in)) < DigitMin));
  assign digit_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrp_otfc.sv
// Bench for rrp_otfc: directed and random operands on a radix-4/4-digit and a radix-2/15-digit
// instance, checked against a positional-sum reference.
module tb_rrp_otfc;

  localparam int RA  = 4;
  localparam int WA  = 4;
  localparam int DA  = 3;
  localparam int OWA = 9;
  localparam int RB  = 2;
  localparam int WB  = 15;
  localparam int DB  = 2;
  localparam int OWB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                  a_in_valid  = 1'b0;
  logic                  a_out_ready = 1'b0;
  logic [DA-1:0]         a_digit     = '0;
  logic                  a_in_ready, a_out_valid, a_digit_err;
  logic signed [OWA-1:0] a_result;

  logic                  b_in_valid  = 1'b0;
  logic                  b_out_ready = 1'b0;
  logic [DB-1:0]         b_digit     = '0;
  logic                  b_in_ready, b_out_valid, b_digit_err;
  logic signed [OWB-1:0] b_result;

  rrp_otfc #(.RADIX(RA), .WIDTH(WA)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .digit_in (a_digit),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .result   (a_result),
    .digit_err(a_digit_err)
  );

  rrp_otfc #(.RADIX(RB), .WIDTH(WB)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .digit_in (b_digit),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .result   (b_result),
    .digit_err(b_digit_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input int d, input int gap);
    a_in_valid = 1'b0;
    repeat (gap) step();
    a_digit    = DA'(d);
    a_in_valid = 1'b1;
    for (int n = 0; n < 20 && !a_in_ready; n++) step();
    if (!a_in_ready) check_eq("a_ready_timeout", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic a_drain(input string tag, input longint expv);
    check_eq({tag, "_valid"}, a_out_valid, 1);
    check_eq({tag, "_result"}, a_result, expv);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check_eq({tag, "_released"}, a_out_valid, 0);
  endtask

  task automatic a_operand(input string tag, input int ds[4], input int maxgap);
    longint acc = 0;
    for (int i = 0; i < WA; i++) begin
      acc = acc * RA + ds[i];
      a_send(ds[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
    end
    a_drain(tag, acc);
  endtask

  task automatic b_send(input int d);
    b_digit    = DB'(d);
    b_in_valid = 1'b1;
    for (int n = 0; n < 20 && !b_in_ready; n++) step();
    if (!b_in_ready) check_eq("b_ready_timeout", b_in_ready, 1);
    step();
    b_in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     dir[4];
    int     rnd[4];
    longint qexp;
    longint acc;

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_result", a_result, 0);
    check_eq("rst_digit_err", a_digit_err, 0);
    check_eq("rst_q", dut_a.q_q, 0);
    check_eq("rst_qm", dut_a.qm_q, -1);

    // Directed 1,-1,0,2: Q tracks the running positional sum and QM stays one below it.
    dir  = '{1, -1, 0, 2};
    qexp = 0;
    for (int i = 0; i < WA; i++) begin
      qexp = qexp * RA + dir[i];
      a_send(dir[i], 0);
      if (i < WA - 1) begin
        check_eq("dir_q", dut_a.q_q, qexp);
        check_eq("dir_qm", dut_a.qm_q, qexp - 1);
      end
    end
    check_eq("dir_valid", a_out_valid, 1);
    check_eq("dir_result", a_result, qexp);

    // Hold the result with a digit already offered; nothing may be taken.
    a_digit    = DA'(1);
    a_in_valid = 1'b1;
    repeat (5) begin
      step();
      check_eq("bp_result", a_result, qexp);
      check_eq("bp_valid", a_out_valid, 1);
      check_eq("bp_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check_eq("handoff_valid", a_out_valid, 0);
    check_eq("handoff_in_ready", a_in_ready, 1);
    check_eq("handoff_q", dut_a.q_q, 0);

    a_operand("all_neg", '{-3, -3, -3, -3}, 0);
    a_operand("all_pos", '{3, 3, 3, 3}, 0);

    for (int i = 0; i < WA; i++) begin
      a_send(0, 0);
      check_eq("zero_q", dut_a.q_q, 0);
      check_eq("zero_qm", dut_a.qm_q, -1);
    end
    a_drain("zeros", 0);

    a_operand("gaps", '{1, -1, 0, 2}, 3);

    a_send(1, 0);
    a_send(2, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_q", dut_a.q_q, 0);
    check_eq("midrst_qm", dut_a.qm_q, -1);
    check_eq("midrst_in_ready", a_in_ready, 1);
    a_operand("post_reset", '{0, 0, 0, 1}, 0);

    for (int i = 0; i < WA; i++) a_send(2, 0);
    check_eq("done_rst_pre", a_out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("done_rst_valid", a_out_valid, 0);
    check_eq("done_rst_result", a_result, 0);

    repeat (40) begin
      for (int i = 0; i < WA; i++) rnd[i] = int'($urandom_range(6, 0)) - 3;
      a_operand("rand_a", rnd, 2);
    end

    // Code -RADIX: converted as given, flagged only when the check is built in.
    a_send(-4, 0);
`ifdef RRP_OTFC_DIGIT_CHECK_EN
    check_eq("illegal_err_set", a_digit_err, 1);
`else
    check_eq("illegal_err_off", a_digit_err, 0);
`endif
    for (int i = 1; i < WA; i++) a_send(0, 0);
    a_drain("illegal", -256);
`ifdef RRP_OTFC_DIGIT_CHECK_EN
    check_eq("illegal_err_sticky", a_digit_err, 1);
`else
    check_eq("illegal_err_still_off", a_digit_err, 0);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("err_after_reset", a_digit_err, 0);

    repeat (1000) begin
      acc = 0;
      for (int i = 0; i < WB; i++) begin
        int d;
        d   = int'($urandom_range(2, 0)) - 1;
        acc = acc * RB + d;
        b_send(d);
      end
      check_eq("rand_b_valid", b_out_valid, 1);
      check_eq("rand_b_result", b_result, acc);
      b_out_ready = 1'b1;
      step();
      b_out_ready = 1'b0;
    end
    check_eq("b_digit_err", b_digit_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
